// File: rtl/ego1_io_pkg.sv
// ----------------------------------------------------------------------------
// ego1_io_pkg
//   Shared definitions for the EGO1 single-step lab input front end.
//   - btn_state_t : encoding of the step-button debounce FSM
//   - DB_CYCLES_BOARD / DB_CYCLES_SIM : debounce lengths for the board
//     (10 ms at 100 MHz) and for fast simulation
//   - AUTO_DIV_BOARD : one auto step per second at 100 MHz
//   - cnt_width() : width of a counter that must hold 0..n-1
// ----------------------------------------------------------------------------
package ego1_io_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PRESS_DB = 2'd1,
        S_HELD     = 2'd2,
        S_REL_DB   = 2'd3
    } btn_state_t;

    localparam int unsigned DB_CYCLES_BOARD = 1_000_000;
    localparam int unsigned DB_CYCLES_SIM   = 4;
    localparam int unsigned AUTO_DIV_BOARD  = 100_000_000;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// ----------------------------------------------------------------------------
// debounce_sync
//   Two-flop synchroniser followed by a level debouncer for one slide switch.
//   The output only follows the synchronised input after it has disagreed
//   with the output for DB_CYCLES consecutive comparisons; any cycle of
//   agreement clears the count, so glitches shorter than DB_CYCLES vanish.
//
//   Ports
//     cp    in   clock, rising edge
//     clr   in   asynchronous reset, active-high
//     din   in   raw level, asynchronous to cp
//     dout  out  debounced level
// ----------------------------------------------------------------------------
module debounce_sync
    import ego1_io_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_BOARD
) (
    input  logic cp,
    input  logic clr,
    input  logic din,
    output logic dout
);

    localparam int unsigned     DB_W    = cnt_width(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync_1;
    logic            sync_2;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge cp or posedge clr) begin
        if (clr) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            db_cnt <= '0;
            dout   <= 1'b0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            if (sync_2 == dout) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                dout   <= sync_2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/ego1_step_input_conditioner.sv
// ----------------------------------------------------------------------------
// ego1_step_input_conditioner
//   Board-side front end for the EGO1 single-step sequential-circuit labs.
//   Cleans up two slide switches and a step push-button and produces a
//   one-cycle step strobe that the lab state machine uses as its update
//   enable. step is a plain strobe: no handshake and no back-pressure; the
//   consumer must act in the single cycle step is high.
//
//   Optional feature: define AUTO_STEP_EN to add a free-running step divider
//   selected by the auto_mode switch. Without it auto_mode is ignored.
//
//   Ports
//     cp        in   clock, rising edge
//     clr       in   asynchronous reset, active-high
//     sw_x1     in   raw switch
//     sw_x2     in   raw switch
//     btn_step  in   raw push-button, high = pressed
//     auto_mode in   raw switch, 1 = free-running steps (AUTO_STEP_EN only)
//     x1        out  debounced sw_x1
//     x2        out  debounced sw_x2
//     step      out  one-cycle step pulse
//     step_cnt  out  steps issued, modulo 2^CNT_W
//
//   The button FSM state is held in 'state' (btn_state_t) for bound checkers.
// ----------------------------------------------------------------------------
module ego1_step_input_conditioner
    import ego1_io_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_BOARD,
    parameter int unsigned AUTO_DIV  = AUTO_DIV_BOARD,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             cp,
    input  logic             clr,
    input  logic             sw_x1,
    input  logic             sw_x2,
    input  logic             btn_step,
    input  logic             auto_mode,
    output logic             x1,
    output logic             x2,
    output logic             step,
    output logic [CNT_W-1:0] step_cnt
);

    localparam int unsigned     DB_W    = cnt_width(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    // ------------------------------------------------------------------
    // Switch levels
    // ------------------------------------------------------------------
    debounce_sync #(.DB_CYCLES(DB_CYCLES)) u_db_x1 (
        .cp   (cp),
        .clr  (clr),
        .din  (sw_x1),
        .dout (x1)
    );

    debounce_sync #(.DB_CYCLES(DB_CYCLES)) u_db_x2 (
        .cp   (cp),
        .clr  (clr),
        .din  (sw_x2),
        .dout (x2)
    );

    // ------------------------------------------------------------------
    // Button synchroniser
    // ------------------------------------------------------------------
    logic btn_s1;
    logic btn_sync;

    always_ff @(posedge cp or posedge clr) begin
        if (clr) begin
            btn_s1   <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_s1   <= btn_step;
            btn_sync <= btn_s1;
        end
    end

    // ------------------------------------------------------------------
    // Button FSM: press and release are both debounced, and only the
    // PRESS_DB -> HELD transition produces a step, so holding the button
    // never repeats and release bounce cannot retrigger.
    // ------------------------------------------------------------------
    btn_state_t      state;
    btn_state_t      state_nx;
    logic [DB_W-1:0] btn_cnt;
    logic [DB_W-1:0] btn_cnt_nx;
    logic            btn_pulse;

    always_ff @(posedge cp or posedge clr) begin
        if (clr) begin
            state   <= S_IDLE;
            btn_cnt <= '0;
        end else begin
            state   <= state_nx;
            btn_cnt <= btn_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        btn_cnt_nx = btn_cnt;
        case (state)
            S_IDLE: begin
                if (btn_sync) begin
                    state_nx   = S_PRESS_DB;
                    btn_cnt_nx = '0;
                end
            end
            S_PRESS_DB: begin
                if (!btn_sync) begin
                    state_nx   = S_IDLE;
                    btn_cnt_nx = '0;
                end else if (btn_cnt == DB_LAST) begin
                    state_nx   = S_HELD;
                    btn_cnt_nx = '0;
                end else begin
                    btn_cnt_nx = btn_cnt + DB_W'(1);
                end
            end
            S_HELD: begin
                if (!btn_sync) begin
                    state_nx   = S_REL_DB;
                    btn_cnt_nx = '0;
                end
            end
            S_REL_DB: begin
                if (btn_sync) begin
                    state_nx   = S_HELD;
                    btn_cnt_nx = '0;
                end else if (btn_cnt == DB_LAST) begin
                    state_nx   = S_IDLE;
                    btn_cnt_nx = '0;
                end else begin
                    btn_cnt_nx = btn_cnt + DB_W'(1);
                end
            end
            default: begin
                state_nx   = S_IDLE;
                btn_cnt_nx = '0;
            end
        endcase
    end

    always_comb begin
        btn_pulse = (state == S_PRESS_DB) && btn_sync && (btn_cnt == DB_LAST);
    end

    // ------------------------------------------------------------------
    // Step source selection
    // ------------------------------------------------------------------
    logic step_src;

`ifdef AUTO_STEP_EN
    localparam int unsigned      DIV_W    = cnt_width(AUTO_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AUTO_DIV - 1);

    logic             auto_s1;
    logic             auto_sync;
    logic [DIV_W-1:0] div_cnt;
    logic             auto_pulse;

    always_ff @(posedge cp or posedge clr) begin
        if (clr) begin
            auto_s1   <= 1'b0;
            auto_sync <= 1'b0;
        end else begin
            auto_s1   <= auto_mode;
            auto_sync <= auto_s1;
        end
    end

    // Held at zero while auto mode is off so the first auto step always
    // lands a full AUTO_DIV cycles after the mode takes effect.
    always_ff @(posedge cp or posedge clr) begin
        if (clr) begin
            div_cnt <= '0;
        end else if (!auto_sync || (div_cnt == DIV_LAST)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_comb begin
        auto_pulse = auto_sync && (div_cnt == DIV_LAST);
        // The button FSM keeps tracking in auto mode; only its pulse is dropped.
        step_src   = auto_sync ? auto_pulse : btn_pulse;
    end
`else
    localparam int unsigned unused_auto_div = AUTO_DIV;
    logic unused_auto_mode;

    assign unused_auto_mode = auto_mode;

    always_comb begin
        step_src = btn_pulse;
    end
`endif

    // ------------------------------------------------------------------
    // Step register and counter; step_cnt shows a step from the cycle
    // after the step pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge cp or posedge clr) begin
        if (clr) begin
            step     <= 1'b0;
            step_cnt <= '0;
        end else begin
            step     <= step_src;
            step_cnt <= step_cnt + CNT_W'(step);
        end
    end

endmodule

// File: tb/tb_ego1_step_input_conditioner.sv
module tb_ego1_step_input_conditioner;
    import ego1_io_pkg::*;

    localparam int DB       = DB_CYCLES_SIM;
    localparam int AUTO_DIV = 8;
    localparam int CNT_W    = 4;
    // Drive after edge c, first sample at c+1: step lands on edge c+1+DB+2.
    localparam int LAT      = DB + 3;

    // ---------------- clock / reset ----------------
    logic             cp = 1'b0;
    logic             clr;
    logic             sw_x1;
    logic             sw_x2;
    logic             btn_step;
    logic             auto_mode;
    logic             x1;
    logic             x2;
    logic             step;
    logic [CNT_W-1:0] step_cnt;

    always #10 cp = ~cp;

    int cyc = 0;
    always @(posedge cp) cyc <= cyc + 1;

    ego1_step_input_conditioner #(
        .DB_CYCLES (DB),
        .AUTO_DIV  (AUTO_DIV),
        .CNT_W     (CNT_W)
    ) dut (
        .cp        (cp),
        .clr       (clr),
        .sw_x1     (sw_x1),
        .sw_x2     (sw_x2),
        .btn_step  (btn_step),
        .auto_mode (auto_mode),
        .x1        (x1),
        .x2        (x2),
        .step      (step),
        .step_cnt  (step_cnt)
    );

    // ---------------- checking ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- scoreboard ----------------
    // exp_q holds the cycle numbers on whose following low phase step must be 1.
    logic [31:0]      exp_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;

    always @(negedge cp) begin
        logic exp_step;
        exp_step = (exp_q.size() > 0) && (exp_q[0] == cyc);
        check("step", {31'd0, step}, {31'd0, exp_step});
        check("step_cnt", {28'd0, step_cnt}, {28'd0, exp_cnt});
        if (exp_step) begin
            void'(exp_q.pop_front());
            exp_cnt = exp_cnt + 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge cp);
            #5;
        end
    endtask

    task automatic apply_clr(input int n);
        clr = 1'b1;
        exp_q.delete();
        exp_cnt = '0;
        tick(n);
        clr = 1'b0;
    endtask

    task automatic do_press(input int hold, input int gap);
        btn_step = 1'b1;
        exp_q.push_back(cyc + LAT);
        tick(hold);
        btn_step = 1'b0;
        tick(gap);
    endtask

    // ---------------- switch vectors ----------------
    typedef struct {
        logic sw1;
        logic sw2;
        int   cycles;
        logic exp1;
        logic exp2;
    } sw_vec_t;

    sw_vec_t vecs[13];

    initial begin
        #(20 * 30000);
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;

        vecs[0]  = '{1'b1, 1'b0, 6, 1'b1, 1'b0};  // x1 rises exactly at the limit
        vecs[1]  = '{1'b1, 1'b1, 5, 1'b1, 1'b0};  // x2 one short
        vecs[2]  = '{1'b1, 1'b1, 1, 1'b1, 1'b1};  // x2 now accepted
        vecs[3]  = '{1'b0, 1'b1, 1, 1'b1, 1'b1};  // 1-cycle low glitch on x1
        vecs[4]  = '{1'b1, 1'b1, 8, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 3, 1'b1, 1'b1};  // DB-1 cycle glitch on both
        vecs[6]  = '{1'b1, 1'b1, 8, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 6, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 6, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 6, 1'b1, 1'b0};  // opposite directions at once
        vecs[10] = '{1'b0, 1'b0, 6, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1, 1'b0, 1'b0};  // 1-cycle high glitch on x1
        vecs[12] = '{1'b0, 1'b0, 8, 1'b0, 1'b0};

        // ---- 1: reset with inputs high ----
        clr = 1'b1; sw_x1 = 1'b1; sw_x2 = 1'b1; btn_step = 1'b1; auto_mode = 1'b0;
        tick(3);
        check("rst_x1", {31'd0, x1}, 32'd0);
        check("rst_x2", {31'd0, x2}, 32'd0);
        check("rst_state", 32'(dut.state), 32'(S_IDLE));
        clr = 1'b0;
        c0 = cyc;
        exp_q.push_back(c0 + LAT);  // button still held through release
        tick(DB + 1);
        check("x1_before_limit", {31'd0, x1}, 32'd0);
        check("x2_before_limit", {31'd0, x2}, 32'd0);
        tick(1);
        check("x1_after_rst", {31'd0, x1}, 32'd1);
        check("x2_after_rst", {31'd0, x2}, 32'd1);
        tick(4);
        sw_x1 = 1'b0; sw_x2 = 1'b0; btn_step = 1'b0;
        tick(12);
        apply_clr(2);
        tick(4);

        // ---- 2: held press gives one step, then a second press ----
        btn_step = 1'b1;
        exp_q.push_back(cyc + LAT);
        tick(LAT - 1);
        check("step_not_early", {31'd0, step}, 32'd0);
        tick(1);
        check("step_on_time", {31'd0, step}, 32'd1);
        tick(1);
        check("step_one_cycle", {31'd0, step}, 32'd0);
        check("cnt_first", {28'd0, step_cnt}, 32'd1);
        tick(12);
        btn_step = 1'b0;
        tick(10);
        do_press(10, 10);
        check("cnt_second", {28'd0, step_cnt}, 32'd2);

        // ---- 3: bouncing press, timed from the last rise ----
        for (int i = 0; i < 2; i++) begin
            btn_step = 1'b1; tick(2);
            btn_step = 1'b0; tick(2);
        end
        do_press(12, 10);
        check("cnt_bounce", {28'd0, step_cnt}, 32'd3);

        // ---- switch table ----
        for (int i = 0; i < 13; i++) begin
            sw_x1 = vecs[i].sw1;
            sw_x2 = vecs[i].sw2;
            tick(vecs[i].cycles);
            check($sformatf("vec%0d_x1", i), {31'd0, x1}, {31'd0, vecs[i].exp1});
            check($sformatf("vec%0d_x2", i), {31'd0, x2}, {31'd0, vecs[i].exp2});
        end

        // ---- x change and step on the same cycle ----
        btn_step = 1'b1;
        exp_q.push_back(cyc + LAT);
        tick(1);
        sw_x1 = 1'b1;
        tick(LAT - 1);
        check("same_cycle_step", {31'd0, step}, 32'd1);
        check("same_cycle_x1", {31'd0, x1}, 32'd1);
        tick(8);
        btn_step = 1'b0; sw_x1 = 1'b0;
        tick(10);

        // ---- 4: counter wrap over 16 presses ----
        apply_clr(2);
        tick(4);
        for (int i = 0; i < 16; i++) begin
            do_press($urandom_range(8, 14), $urandom_range(8, 12));
            if (i == 14) check("cnt_15", {28'd0, step_cnt}, 32'd15);
        end
        check("cnt_wrap", {28'd0, step_cnt}, 32'd0);

        // ---- 5: reset during press debounce ----
        btn_step = 1'b1;
        exp_q.push_back(cyc + LAT);
        tick(4);
        check("in_press_db", 32'(dut.state), 32'(S_PRESS_DB));
        apply_clr(3);
        exp_q.push_back(cyc + LAT);
        tick(12);
        btn_step = 1'b0;
        tick(10);
        check("cnt_after_mid_rst", {28'd0, step_cnt}, 32'd1);

        // ---- 6: auto mode ----
        c0 = cyc;
        auto_mode = 1'b1;
`ifdef AUTO_STEP_EN
        for (int k = 1; 2 + AUTO_DIV * k <= 42; k++) exp_q.push_back(c0 + 2 + AUTO_DIV * k);
`endif
        tick(12);
        btn_step = 1'b1;
`ifndef AUTO_STEP_EN
        exp_q.push_back(cyc + LAT);
`endif
        tick(10);
        btn_step = 1'b0;
        tick(18);
        auto_mode = 1'b0;
        tick(30);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
